ms_alu_sequencer: RTL and testbench

// - FSM that sequences the shared 10-bit bus, register file and ALU (A reg, G reg, tri-state Gout).
// - Accepts one instruction word per Run request and drives register enables, bus drivers, Ain/Gin/Gout
//   and ALUControl, one control step per clock; pulses Done on the final step.
// - Sits between the instruction source (switches/memory) and the datapath; no data passes through it.

---
 rtl/ms_alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_ms_alu_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_alu_sequencer.sv
// Control sequencer for the shared-bus register file / ALU datapath.
// Optional illegal-opcode trap flag enabled by defining MS_SEQ_ILLEGAL_TRAP_EN.
module ms_alu_sequencer #(
  parameter int IW  = 10,
  parameter int RSW = 2
) (
  input  logic                CLKb,
  input  logic                Clear,
  input  logic                Run,
  input  logic [IW-1:0]       INSTR,
  output logic [2**RSW-1:0]   Rin,
  output logic [2**RSW-1:0]   Rout,
  output logic                Extern,
  output logic                Ain,
  output logic                Gin,
  output logic                Gout,
  output logic [2:0]          ALUControl,
  output logic                Busy,
  output logic                Done,
  output logic                Err
);

  // state | meaning
  // IDLE  | waiting for Run, all controls low
  // T1    | first control step of the captured instruction
  // T2    | second step (INV write-back, binary-op compute)
  // T3    | binary-op write-back from G
  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  localparam int NREG = 2**RSW;

  state_t          state;
  logic [IW-1:0]   ir;
  logic [3:0]      op;
  logic [RSW-1:0]  rx, ry;
  logic [NREG-1:0] dx, dy;
  logic            is_load, is_copy, is_inv, is_bin, is_ill;
  logic [2:0]      alu_op;
  logic            unused_ir;

  assign op = ir[IW-1 -: 4];
  assign rx = ir[IW-5 -: RSW];
  assign ry = ir[IW-5-RSW -: RSW];
  assign dx = {{(NREG-1){1'b0}}, 1'b1} << rx;
  assign dy = {{(NREG-1){1'b0}}, 1'b1} << ry;
  // low instruction bits carry no meaning but are still captured whole
  assign unused_ir = ^ir;

  assign is_ill  = op[3];
  assign is_load = (op == 4'b0000);
  assign is_copy = (op == 4'b0001);
  assign is_inv  = (op == 4'b0100);

  always_comb begin
    is_bin = 1'b1;
    alu_op = 3'b000;
    case (op)
      4'b0010: alu_op = 3'b000;
      4'b0011: alu_op = 3'b001;
      4'b0101: alu_op = 3'b011;
      4'b0110: alu_op = 3'b100;
      4'b0111: alu_op = 3'b101;
      default: is_bin = 1'b0;
    endcase
  end

  always_ff @(posedge CLKb) begin
    if (Clear) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      case (state)
        S_IDLE: if (Run) begin
          ir    <= INSTR;
          state <= S_T1;
        end
        S_T1:    state <= (is_inv || is_bin) ? S_T2 : S_IDLE;
        S_T2:    state <= is_bin ? S_T3 : S_IDLE;
        S_T3:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    Rin        = '0;
    Rout       = '0;
    Extern     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    ALUControl = 3'b000;
    Done       = 1'b0;
    Err        = 1'b0;
    case (state)
      S_T1: begin
        if (is_load) begin
          Extern = 1'b1;
          Rin    = dx;
          Done   = 1'b1;
        end else if (is_copy) begin
          Rout = dy;
          Rin  = dx;
          Done = 1'b1;
        end else if (is_inv) begin
          Rout       = dy;
          Gin        = 1'b1;
          ALUControl = 3'b010;
        end else if (is_bin) begin
          Rout = dx;
          Ain  = 1'b1;
        end else begin
          Done = 1'b1;
`ifdef MS_SEQ_ILLEGAL_TRAP_EN
          Err  = is_ill;
`else
          Err  = 1'b0;
`endif
        end
      end
      S_T2: begin
        if (is_inv) begin
          Gout = 1'b1;
          Rin  = dx;
          Done = 1'b1;
        end else if (is_bin) begin
          Rout       = dy;
          Gin        = 1'b1;
          ALUControl = alu_op;
        end
      end
      S_T3: begin
        Gout = 1'b1;
        Rin  = dx;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_ms_alu_sequencer.sv
// Self-checking bench for ms_alu_sequencer: directed scenarios plus randomized
// instruction streams checked against a micro-step reference model.
module tb_ms_alu_sequencer;

  logic       CLKb = 1'b0;
  logic       Clear = 1'b0;
  logic       Run = 1'b0;
  logic [9:0] INSTR = '0;
  logic [3:0] Rin, Rout;
  logic       Extern, Ain, Gin, Gout, Busy, Done, Err;
  logic [2:0] ALUControl;

  int total = 0;
  int bad = 0;

`ifdef MS_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  ms_alu_sequencer dut (
    .CLKb(CLKb), .Clear(Clear), .Run(Run), .INSTR(INSTR),
    .Rin(Rin), .Rout(Rout), .Extern(Extern), .Ain(Ain), .Gin(Gin),
    .Gout(Gout), .ALUControl(ALUControl), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 CLKb = ~CLKb;

  // {Rin, Rout, Extern, Ain, Gin, Gout, ALUControl, Busy, Done, Err}
  logic [17:0] obs;
  assign obs = {Rin, Rout, Extern, Ain, Gin, Gout, ALUControl, Busy, Done, Err};

  logic [17:0] exp_q[$];

  function automatic logic [17:0] mk(input logic [3:0] rin, input logic [3:0] rout,
                                     input bit ext, input bit ain, input bit gin,
                                     input bit gout, input logic [2:0] alu,
                                     input bit done, input bit err);
    return {rin, rout, ext, ain, gin, gout, alu, 1'b1, done, err};
  endfunction

  // Micro-step list for one instruction, one entry per busy cycle.
  function automatic void model(input logic [9:0] instr);
    logic [3:0] op;
    logic [3:0] dx, dy;
    op = instr[9:6];
    dx = 4'(1 << instr[5:4]);
    dy = 4'(1 << instr[3:2]);
    exp_q.delete();
    if (op >= 4'd8) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 1, TRAP));
    end else if (op == 4'd0) begin
      exp_q.push_back(mk(dx, 0, 1, 0, 0, 0, 3'd0, 1, 0));
    end else if (op == 4'd1) begin
      exp_q.push_back(mk(dx, dy, 0, 0, 0, 0, 3'd0, 1, 0));
    end else if (op == 4'd4) begin
      exp_q.push_back(mk(0, dy, 0, 0, 1, 0, 3'd2, 0, 0));
      exp_q.push_back(mk(dx, 0, 0, 0, 0, 1, 3'd0, 1, 0));
    end else begin
      logic [2:0] code;
      case (op)
        4'd2: code = 3'd0;
        4'd3: code = 3'd1;
        4'd5: code = 3'd3;
        4'd6: code = 3'd4;
        default: code = 3'd5;
      endcase
      exp_q.push_back(mk(0, dx, 0, 1, 0, 0, 3'd0, 0, 0));
      exp_q.push_back(mk(0, dy, 0, 0, 1, 0, code, 0, 0));
      exp_q.push_back(mk(dx, 0, 0, 0, 0, 1, 3'd0, 1, 0));
    end
  endfunction

  task automatic test_reset();
    Clear = 1'b1; Run = 1'b1; INSTR = 10'h3FF;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLKb);
      total++;
      if (obs !== 18'd0) begin
        bad++; $display("FAIL reset_outputs cyc%0d: got %b want %b", i, obs, 18'd0);
      end
    end
    Clear = 1'b0; INSTR = 10'b0000_01_00_00;
    @(negedge CLKb);
    Run = 1'b0;
    total++;
    if (obs !== mk(4'b0010, 0, 1, 0, 0, 0, 3'd0, 1, 0)) begin
      bad++; $display("FAIL reset_release_accept: got %b", obs);
    end
    @(negedge CLKb);
    total++;
    if (obs !== 18'd0) begin
      bad++; $display("FAIL reset_release_idle: got %b want 0", obs);
    end
  endtask

  task automatic test_load();
    INSTR = 10'b0000_01_00_00; Run = 1'b1;
    @(negedge CLKb);
    Run = 1'b0;
    total++;
    if (Extern !== 1'b1 || Rin !== 4'b0010 || Done !== 1'b1 || Rout !== 4'b0000 || Busy !== 1'b1) begin
      bad++; $display("FAIL load_t1: got %b", obs);
    end
    @(negedge CLKb);
    total++;
    if (obs !== 18'd0) begin
      bad++; $display("FAIL load_idle: got %b want 0", obs);
    end
  endtask

  task automatic test_add();
    INSTR = 10'b0010_00_01_00; Run = 1'b1;
    @(negedge CLKb);
    Run = 1'b0;
    total++;
    if (obs !== mk(0, 4'b0001, 0, 1, 0, 0, 3'd0, 0, 0)) begin
      bad++; $display("FAIL add_t1: got %b", obs);
    end
    @(negedge CLKb);
    total++;
    if (obs !== mk(0, 4'b0010, 0, 0, 1, 0, 3'd0, 0, 0)) begin
      bad++; $display("FAIL add_t2: got %b", obs);
    end
    @(negedge CLKb);
    total++;
    if (obs !== mk(4'b0001, 0, 0, 0, 0, 1, 3'd0, 1, 0)) begin
      bad++; $display("FAIL add_t3: got %b", obs);
    end
    @(negedge CLKb);
    total++;
    if (obs !== 18'd0) begin
      bad++; $display("FAIL add_idle: got %b want 0", obs);
    end
  endtask

  task automatic test_inv_run_ignored();
    INSTR = 10'b0100_10_11_00; Run = 1'b1;
    @(negedge CLKb);
    INSTR = 10'b0000_00_00_00;  // Run stays high through T1, must be ignored
    total++;
    if (obs !== mk(0, 4'b1000, 0, 0, 1, 0, 3'b010, 0, 0)) begin
      bad++; $display("FAIL inv_t1: got %b", obs);
    end
    @(negedge CLKb);
    Run = 1'b0;
    total++;
    if (obs !== mk(4'b0100, 0, 0, 0, 0, 1, 3'd0, 1, 0)) begin
      bad++; $display("FAIL inv_t2: got %b", obs);
    end
    @(negedge CLKb);
    total++;
    if (obs !== 18'd0) begin
      bad++; $display("FAIL inv_idle: got %b want 0", obs);
    end
  endtask

  task automatic test_clear_mid();
    INSTR = 10'b0011_01_10_00; Run = 1'b1;
    @(negedge CLKb);
    Run = 1'b0;
    total++;
    if (obs !== mk(0, 4'b0010, 0, 1, 0, 0, 3'd0, 0, 0)) begin
      bad++; $display("FAIL sub_t1: got %b", obs);
    end
    @(negedge CLKb);
    total++;
    if (obs !== mk(0, 4'b0100, 0, 0, 1, 0, 3'b001, 0, 0)) begin
      bad++; $display("FAIL sub_t2: got %b", obs);
    end
    Clear = 1'b1;
    @(negedge CLKb);
    Clear = 1'b0;
    total++;
    if (obs !== 18'd0) begin
      bad++; $display("FAIL clear_mid_outputs: got %b want 0", obs);
    end
    total++;
    if (dut.ir !== 10'd0) begin
      bad++; $display("FAIL clear_mid_ir: got %h want 000", dut.ir);
    end
    @(negedge CLKb);
    total++;
    if (obs !== 18'd0) begin
      bad++; $display("FAIL clear_mid_stay_idle: got %b want 0", obs);
    end
  endtask

  task automatic test_illegal();
    INSTR = 10'b1010_11_01_10; Run = 1'b1;
    @(negedge CLKb);
    Run = 1'b0;
    total++;
    if (obs !== mk(0, 0, 0, 0, 0, 0, 3'd0, 1, TRAP)) begin
      bad++; $display("FAIL illegal_t1: got %b want %b", obs, mk(0, 0, 0, 0, 0, 0, 3'd0, 1, TRAP));
    end
    @(negedge CLKb);
    total++;
    if (obs !== 18'd0) begin
      bad++; $display("FAIL illegal_idle: got %b want 0", obs);
    end
  endtask

  task automatic test_back_to_back();
    // Run held high: LOAD, one IDLE cycle, LOAD again
    INSTR = 10'b0000_10_00_00; Run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLKb);
      total++;
      if (obs !== mk(4'b0100, 0, 1, 0, 0, 0, 3'd0, 1, 0)) begin
        bad++; $display("FAIL b2b_t1_%0d: got %b", i, obs);
      end
      @(negedge CLKb);
      if (i == 1) Run = 1'b0;
      total++;
      if (obs !== 18'd0) begin
        bad++; $display("FAIL b2b_gap_%0d: got %b want 0", i, obs);
      end
    end
    @(negedge CLKb);
    total++;
    if (obs !== 18'd0) begin
      bad++; $display("FAIL b2b_stop: got %b want 0", obs);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [9:0] instr;
      instr = 10'($urandom);
      model(instr);
      INSTR = instr; Run = 1'b1;
      while (exp_q.size() > 0) begin
        logic [17:0] e;
        e = exp_q.pop_front();
        @(negedge CLKb);
        Run = 1'($urandom);
        INSTR = 10'($urandom);
        total++;
        if (obs !== e) begin
          bad++; $display("FAIL rand_step instr=%b: got %b want %b", instr, obs, e);
        end
        total++;
        if ($countones({Rout, Extern, Gout}) > 1 || $countones(Rin) > 1) begin
          bad++; $display("FAIL rand_bus_rule instr=%b: got %b want onehot0", instr, obs);
        end
      end
      @(negedge CLKb);
      Run = 1'b0;
      total++;
      if (obs !== 18'd0) begin
        bad++; $display("FAIL rand_idle instr=%b: got %b want 0", instr, obs);
      end
      repeat ($urandom_range(0, 2)) @(negedge CLKb);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add();
    test_inv_run_ignored();
    test_clear_mid();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
